// File: rtl/otter_arb_pkg.sv
// otter_arb_pkg: shared types for the OTTER memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GNT_I, GNT_D)
//   arb_owner_t : which requester port owns / last owned the shared bus
package otter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// otter_mem_arbiter_if: bundle of every bus signal around otter_mem_arbiter,
// for harnesses and integration code that want a single handle.
//   master : requester side (instruction fetch + data port), drives requests
//   slave  : shared-memory side, drives completion and read data
//   arb    : arbiter view of the whole bundle
interface otter_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_r_data;
  logic              imem_ack;

  logic              dmem_re;
  logic              dmem_we;
  logic [SEL_W-1:0]  dmem_sel;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_w_data;
  logic [DATA_W-1:0] dmem_r_data;
  logic              dmem_ack;

  logic              mem_req;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_r_data;

  modport master (
    output imem_req, imem_addr, dmem_re, dmem_we, dmem_sel, dmem_addr, dmem_w_data,
    input  imem_r_data, imem_ack, dmem_r_data, dmem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_sel, mem_addr, mem_w_data,
    output mem_ack, mem_r_data
  );

  modport arb (
    input  imem_req, imem_addr, dmem_re, dmem_we, dmem_sel, dmem_addr, dmem_w_data,
           mem_ack, mem_r_data,
    output imem_r_data, imem_ack, dmem_r_data, dmem_ack,
           mem_req, mem_we, mem_sel, mem_addr, mem_w_data
  );

endinterface

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: arbitrates an instruction-fetch port and a data port onto
// one shared memory bus. One transaction in flight at a time.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_imem_* / o_imem_* : fetch request/address in, data/ack pulse out
//   i_dmem_* / o_dmem_* : data read/write request in, read data/ack pulse out
//   o_mem_* / i_mem_*   : shared memory bus (req held until i_mem_ack)
// Build option: OTTER_ARB_RR_EN -- ties alternate between ports instead of
// the data port always winning.
//
// state | meaning
// IDLE  | no owner; arbitrate, latch winner's request
// GNT_I | fetch owns the bus, waiting for i_mem_ack
// GNT_D | data port owns the bus, waiting for i_mem_ack
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_imem_req,
  input  logic [ADDR_W-1:0]     i_imem_addr,
  output logic [DATA_W-1:0]     o_imem_r_data,
  output logic                  o_imem_ack,
  input  logic                  i_dmem_re,
  input  logic                  i_dmem_we,
  input  logic [DATA_W/8-1:0]   i_dmem_sel,
  input  logic [ADDR_W-1:0]     i_dmem_addr,
  input  logic [DATA_W-1:0]     i_dmem_w_data,
  output logic [DATA_W-1:0]     o_dmem_r_data,
  output logic                  o_dmem_ack,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_W/8-1:0]   o_mem_sel,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_w_data,
  input  logic                  i_mem_ack,
  input  logic [DATA_W-1:0]     i_mem_r_data
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              dreq;
  logic              grant_d;

  assign dreq = i_dmem_re | i_dmem_we;

`ifdef OTTER_ARB_RR_EN
  arb_owner_t last_q;

  // On a tie the data port wins only if fetch was granted last.
  assign grant_d = dreq & (~i_imem_req | (last_q == OWNER_I));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= OWNER_I;
    end else if (state_q == IDLE) begin
      if (state_d == GNT_D)      last_q <= OWNER_D;
      else if (state_d == GNT_I) last_q <= OWNER_I;
    end
  end
`else
  assign grant_d = dreq;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)         state_d = GNT_D;
        else if (i_imem_req) state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (i_mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs come only from the latched request, so requesters may
  // change or drop their inputs while a transaction is in flight.
  assign o_mem_req    = (state_q != IDLE);
  assign o_mem_we     = we_q;
  assign o_mem_sel    = sel_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_w_data = wdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q        <= '0;
      sel_q         <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      o_imem_ack    <= 1'b0;
      o_dmem_ack    <= 1'b0;
      o_imem_r_data <= '0;
      o_dmem_r_data <= '0;
    end else begin
      o_imem_ack <= 1'b0;
      o_dmem_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d == GNT_D) begin
            addr_q  <= i_dmem_addr;
            sel_q   <= i_dmem_sel;
            wdata_q <= i_dmem_w_data;
            we_q    <= i_dmem_we;  // re+we together is a write
          end else if (state_d == GNT_I) begin
            addr_q  <= i_imem_addr;
            sel_q   <= '1;
            wdata_q <= '0;
            we_q    <= 1'b0;
          end
        end
        GNT_I: begin
          if (i_mem_ack) begin
            o_imem_ack    <= 1'b1;
            o_imem_r_data <= i_mem_r_data;
          end
        end
        GNT_D: begin
          if (i_mem_ack) begin
            o_dmem_ack <= 1'b1;
            if (!we_q) o_dmem_r_data <= i_mem_r_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
module tb_otter_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_imem_req    (bus.imem_req),
    .i_imem_addr   (bus.imem_addr),
    .o_imem_r_data (bus.imem_r_data),
    .o_imem_ack    (bus.imem_ack),
    .i_dmem_re     (bus.dmem_re),
    .i_dmem_we     (bus.dmem_we),
    .i_dmem_sel    (bus.dmem_sel),
    .i_dmem_addr   (bus.dmem_addr),
    .i_dmem_w_data (bus.dmem_w_data),
    .o_dmem_r_data (bus.dmem_r_data),
    .o_dmem_ack    (bus.dmem_ack),
    .o_mem_req     (bus.mem_req),
    .o_mem_we      (bus.mem_we),
    .o_mem_sel     (bus.mem_sel),
    .o_mem_addr    (bus.mem_addr),
    .o_mem_w_data  (bus.mem_w_data),
    .i_mem_ack     (bus.mem_ack),
    .i_mem_r_data  (bus.mem_r_data)
  );

  // Memory model: acks after (1 + mem_stall) cycles of o_mem_req.
  logic        mem_auto = 1'b1;
  int          mem_stall = 0;
  int          mem_cnt = 0;
  logic        ack_auto = 1'b0, ack_man = 1'b0;
  logic [31:0] rdata_auto = '0, rdata_man = '0;

  assign bus.mem_ack    = mem_auto ? ack_auto : ack_man;
  assign bus.mem_r_data = mem_auto ? rdata_auto : rdata_man;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(negedge clk) begin
    if (!bus.mem_req || rst) begin
      mem_cnt  <= 0;
      ack_auto <= 1'b0;
    end else begin
      mem_cnt <= mem_cnt + 1;
      if (mem_cnt + 1 > mem_stall + 1) begin
        ack_auto   <= 1'b1;
        rdata_auto <= mem_model(bus.mem_addr);
      end else begin
        ack_auto <= 1'b0;
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
  } ack_exp_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor
  logic        prev_req = 1'b0, prev_iack = 1'b0, prev_dack = 1'b0;
  logic [31:0] held_addr = '0;

  always @(negedge clk) begin : monitor
    mem_exp_t me;
    ack_exp_t ae;
    if (!rst) begin
      if (bus.mem_req && !prev_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(bus.mem_req), 32'd0);
        end else begin
          me = mem_q.pop_front();
          chk("mem_addr", bus.mem_addr, me.addr);
          chk("mem_we", 32'(bus.mem_we), 32'(me.we));
          chk("mem_sel", 32'(bus.mem_sel), 32'(me.sel));
          chk("mem_w_data", bus.mem_w_data, me.wdata);
        end
        held_addr <= bus.mem_addr;
      end else if (bus.mem_req) begin
        chk("mem_addr_stable", bus.mem_addr, held_addr);
      end
      if (bus.imem_ack && bus.dmem_ack) chk("dual_ack", 32'd1, 32'd0);
      if (bus.imem_ack) begin
        chk("imem_ack_width", 32'(prev_iack), 32'd0);
        if (ack_q.size() == 0) begin
          chk("unexpected_imem_ack", 32'd1, 32'd0);
        end else begin
          ae = ack_q.pop_front();
          chk("ack_owner_i", 32'(ae.is_d), 32'd0);
          chk("imem_r_data", bus.imem_r_data, ae.rdata);
        end
      end
      if (bus.dmem_ack) begin
        chk("dmem_ack_width", 32'(prev_dack), 32'd0);
        if (ack_q.size() == 0) begin
          chk("unexpected_dmem_ack", 32'd1, 32'd0);
        end else begin
          ae = ack_q.pop_front();
          chk("ack_owner_d", 32'(ae.is_d), 32'd1);
          chk("dmem_r_data", bus.dmem_r_data, ae.rdata);
        end
      end
    end
    prev_req  <= bus.mem_req;
    prev_iack <= bus.imem_ack;
    prev_dack <= bus.dmem_ack;
  end

  // Stimulus helpers
  task automatic push_i(input logic [31:0] addr, input logic [31:0] rdata);
    mem_q.push_back('{addr, 1'b0, 4'hF, 32'h0});
    ack_q.push_back('{1'b0, rdata});
  endtask

  task automatic push_d(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata);
    mem_q.push_back('{addr, we, sel, wdata});
    ack_q.push_back('{1'b1, rdata});
  endtask

  task automatic req_i(input logic [31:0] addr, output int lat);
    lat = -1;
    bus.imem_req  = 1'b1;
    bus.imem_addr = addr;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.imem_ack) begin
        lat = k + 1;
        break;
      end
    end
    bus.imem_req = 1'b0;
    if (lat < 0) chk("imem_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic req_d(input logic re, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    lat = -1;
    bus.dmem_re     = re;
    bus.dmem_we     = we;
    bus.dmem_sel    = sel;
    bus.dmem_addr   = addr;
    bus.dmem_w_data = wdata;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.dmem_ack) begin
        lat = k + 1;
        break;
      end
    end
    bus.dmem_re = 1'b0;
    bus.dmem_we = 1'b0;
    if (lat < 0) chk("dmem_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_imem_ack"}, 32'(bus.imem_ack), 32'd0);
    chk({tag, "_dmem_ack"}, 32'(bus.dmem_ack), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_sel"}, 32'(bus.mem_sel), 32'd0);
    chk({tag, "_mem_w_data"}, bus.mem_w_data, 32'd0);
    chk({tag, "_imem_r_data"}, bus.imem_r_data, 32'd0);
    chk({tag, "_dmem_r_data"}, bus.dmem_r_data, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] tie_d_addr [2];
  logic [31:0] tie_d_data [2];
  logic [31:0] tie_i_addr [2];
  logic [31:0] tie_i_data [2];

  initial begin : stim
    int lat, lat_d, lat_i;
    tie_d_addr = '{32'h4000, 32'h4010};
    tie_d_data = '{32'hA5A5_4000, 32'hA5A5_4010};
    tie_i_addr = '{32'h0200, 32'h0210};
    tie_i_data = '{32'hA5A5_0200, 32'hA5A5_0210};

    bus.imem_req = 1'b0; bus.imem_addr = '0;
    bus.dmem_re = 1'b0; bus.dmem_we = 1'b0; bus.dmem_sel = '0;
    bus.dmem_addr = '0; bus.dmem_w_data = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fetch, zero-wait memory
    push_i(32'h100, 32'h0000_0013);
    req_i(32'h100, lat);
    chk("imem_latency", 32'(lat), 32'd3);

    // Data read, write, read+write-as-write
    push_d(1'b0, 4'hF, 32'h3000, 32'h0, 32'hA5A5_3000);
    req_d(1'b1, 1'b0, 4'hF, 32'h3000, 32'h0, lat);
    chk("dmem_read_latency", 32'(lat), 32'd3);

    push_d(1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF, 32'hA5A5_3000);
    req_d(1'b0, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF, lat);

    push_d(1'b1, 4'hC, 32'h2004, 32'h1234_5678, 32'hA5A5_3000);
    req_d(1'b1, 1'b1, 4'hC, 32'h2004, 32'h1234_5678, lat);
    @(negedge clk);
    chk("dmem_r_data_hold", bus.dmem_r_data, 32'hA5A5_3000);
    chk("imem_r_data_hold", bus.imem_r_data, 32'h0000_0013);

    // Ties from IDLE: data first, fetch after one bubble, twice
    pulse_reset();
    for (int t = 0; t < 2; t++) begin
      push_d(1'b0, 4'hF, tie_d_addr[t], 32'h0, tie_d_data[t]);
      push_i(tie_i_addr[t], tie_i_data[t]);
      fork
        req_d(1'b1, 1'b0, 4'hF, tie_d_addr[t], 32'h0, lat_d);
        req_i(tie_i_addr[t], lat_i);
      join
      chk("tie_dmem_latency", 32'(lat_d), 32'd3);
      chk("tie_imem_latency", 32'(lat_i), 32'd6);
      @(negedge clk);
    end

    // Back-to-back ties: both ports re-request immediately after each ack
`ifdef OTTER_ARB_RR_EN
    push_d(1'b0, 4'hF, 32'h4100, 32'h0, 32'hA5A5_4100);
    push_i(32'h0300, 32'hA5A5_0300);
    push_d(1'b0, 4'hF, 32'h4104, 32'h0, 32'hA5A5_4104);
    push_i(32'h0304, 32'hA5A5_0304);
`else
    push_d(1'b0, 4'hF, 32'h4100, 32'h0, 32'hA5A5_4100);
    push_d(1'b0, 4'hF, 32'h4104, 32'h0, 32'hA5A5_4104);
    push_i(32'h0300, 32'hA5A5_0300);
    push_i(32'h0304, 32'hA5A5_0304);
`endif
    fork
      begin
        int l0, l1;
        req_d(1'b1, 1'b0, 4'hF, 32'h4100, 32'h0, l0);
        req_d(1'b1, 1'b0, 4'hF, 32'h4104, 32'h0, l1);
      end
      begin
        int l2, l3;
        req_i(32'h0300, l2);
        req_i(32'h0304, l3);
      end
    join
    @(negedge clk);

    // Memory stall of 5 extra cycles
    mem_stall = 5;
    push_d(1'b0, 4'hF, 32'h5000, 32'h0, 32'hA5A5_5000);
    req_d(1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, lat);
    chk("stall_latency", 32'(lat), 32'd8);
    mem_stall = 0;
    @(negedge clk);

    // Reset while in GNT_D, then a late memory ack
    mem_auto = 1'b0;
    mem_q.push_back('{32'h6000, 1'b1, 4'hF, 32'hCAFE_F00D});
    bus.dmem_we = 1'b1; bus.dmem_sel = 4'hF;
    bus.dmem_addr = 32'h6000; bus.dmem_w_data = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    chk("gnt_d_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    bus.dmem_we = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    ack_man = 1'b1;
    rdata_man = 32'h0000_0055;
    @(negedge clk);
    ack_man = 1'b0;
    repeat (4) begin
      chk("late_ack_dmem_ack", 32'(bus.dmem_ack), 32'd0);
      chk("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
      @(negedge clk);
    end
    mem_auto = 1'b1;

    push_i(32'h100, 32'h0000_0013);
    req_i(32'h100, lat);
    chk("post_reset_imem_latency", 32'(lat), 32'd3);
    repeat (2) @(negedge clk);

    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
